// File: rtl/move_checker.sv
// Move legality stage: captures a console move, scans the source and destination tableaux one
// slot per cycle and validates it. Optional MOVE_COUNT_EN adds a saturating move_count output.
module move_checker #(
    parameter int CARD_W    = 7,
    parameter int TAB_DEPTH = 19,
    parameter int CNT_W     = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic                          ready,
    output logic                          successful,
    input  logic                          input_ready,
    input  logic [3:0]                    source,
    input  logic [3:0]                    source_offset,
    input  logic [3:0]                    destination,
    input  logic [CARD_W-1:0]             talon_top,
    input  logic                          stock_empty,
    input  logic [TAB_DEPTH*CARD_W-1:0]   tableau1,
    input  logic [TAB_DEPTH*CARD_W-1:0]   tableau2,
    input  logic [TAB_DEPTH*CARD_W-1:0]   tableau3,
    input  logic [TAB_DEPTH*CARD_W-1:0]   tableau4,
    input  logic [TAB_DEPTH*CARD_W-1:0]   tableau5,
    input  logic [TAB_DEPTH*CARD_W-1:0]   tableau6,
    input  logic [TAB_DEPTH*CARD_W-1:0]   tableau7,
    input  logic [4*CARD_W-1:0]           foundation_cards,
    output logic                          mv_valid,
    output logic [3:0]                    mv_src,
    output logic [3:0]                    mv_offset,
    output logic [3:0]                    mv_dst,
    input  logic                          mv_done
`ifdef MOVE_COUNT_EN
    ,
    output logic [CNT_W-1:0]              move_count
`endif
);
    localparam int IDX_W = 5;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TAB_DEPTH - 1);

    typedef enum logic [2:0] {IDLE, PROMPT, WAIT_IN, SCAN_SRC, SCAN_DST, CHECK, EXEC, REJECT} state_t;

    state_t             state_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic [3:0]         src_reg, off_reg, dst_reg;
    logic [IDX_W-1:0]   src_top_reg, src_up_reg;
    logic               src_empty_reg;
    logic [CARD_W-1:0]  dst_top_reg;
    logic               dst_empty_reg;
    logic               legal_reg, check_phase_reg;

    logic [TAB_DEPTH*CARD_W-1:0] pile_bus [0:7];
    logic [TAB_DEPTH*CARD_W-1:0] src_pile, dst_pile;
    logic [CARD_W-1:0]  src_slot [0:TAB_DEPTH-1];
    logic [CARD_W-1:0]  dst_slot [0:TAB_DEPTH-1];
    logic [CARD_W-1:0]  found_slot [0:3];
    logic [CARD_W-1:0]  scan_card, base_card, base_tab, f_card;
    logic [IDX_W-1:0]   base_idx;
    logic [4:0]         base_rank, f_rank, dst_rank;
    logic               src_tab, dst_tab, found_ok, tab_ok, legal;
    logic               unused_bits;

    assign pile_bus[0] = '0;
    assign pile_bus[1] = tableau1;
    assign pile_bus[2] = tableau2;
    assign pile_bus[3] = tableau3;
    assign pile_bus[4] = tableau4;
    assign pile_bus[5] = tableau5;
    assign pile_bus[6] = tableau6;
    assign pile_bus[7] = tableau7;

    assign src_tab = (src_reg >= 4'd1) && (src_reg <= 4'd7);
    assign dst_tab = (dst_reg >= 4'd1) && (dst_reg <= 4'd7);
    assign src_pile = src_tab ? pile_bus[src_reg[2:0]] : '0;
    assign dst_pile = dst_tab ? pile_bus[dst_reg[2:0]] : '0;

    genvar gi;
    generate
        for (gi = 0; gi < TAB_DEPTH; gi++) begin : g_slot
            assign src_slot[gi] = src_pile[gi*CARD_W +: CARD_W];
            assign dst_slot[gi] = dst_pile[gi*CARD_W +: CARD_W];
        end
        for (gi = 0; gi < 4; gi++) begin : g_found
            assign found_slot[gi] = foundation_cards[gi*CARD_W +: CARD_W];
        end
    endgenerate

    // Base card sits offset slots below the top of the source pile.
    assign base_idx = src_top_reg - {1'b0, off_reg};

    always_comb begin
        scan_card = '0;
        base_tab  = '0;
        for (int i = 0; i < TAB_DEPTH; i++) begin
            if (idx_reg == IDX_W'(i))
                scan_card = (state_reg == SCAN_SRC) ? src_slot[i] : dst_slot[i];
            if (base_idx == IDX_W'(i))
                base_tab = src_slot[i];
        end
    end

    assign base_card = (src_reg == 4'd0) ? talon_top : base_tab;
    assign f_card    = found_slot[base_card[2:1]];
    assign base_rank = {1'b0, base_card[CARD_W-1 -: 4]};
    assign f_rank    = {1'b0, f_card[CARD_W-1 -: 4]};
    assign dst_rank  = {1'b0, dst_top_reg[CARD_W-1 -: 4]};
    assign found_ok  = (base_rank == f_rank + 5'd1);
    assign tab_ok    = dst_empty_reg ? (base_rank == 5'd13)
                     : (dst_top_reg[0] && (dst_rank == base_rank + 5'd1) && (dst_top_reg[1] != base_card[1]));

    always_comb begin
        legal = 1'b1;
        if (src_reg >= 4'd9) begin
            legal = 1'b0;
        end else if (src_reg == 4'd8) begin
            legal = !(stock_empty && (talon_top == '0));
        end else begin
            if (dst_reg > 4'd7)                                   legal = 1'b0;
            if (src_tab && (src_reg == dst_reg))                  legal = 1'b0;
            if ((src_reg == 4'd0) && (talon_top == '0))           legal = 1'b0;
            if (src_tab && src_empty_reg)                         legal = 1'b0;
            if (src_tab && (({1'b0, off_reg} + 5'd1) > src_up_reg)) legal = 1'b0;
            if ((dst_reg == 4'd0) && (off_reg != 4'd0))           legal = 1'b0;
            if ((dst_reg == 4'd0) && !found_ok)                   legal = 1'b0;
            if (dst_tab && !tab_ok)                               legal = 1'b0;
        end
    end

    assign unused_bits = ^{f_card[2:0], dst_top_reg[2], base_card[0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= IDLE;
            ready           <= 1'b0;
            successful      <= 1'b0;
            mv_valid        <= 1'b0;
            mv_src          <= '0;
            mv_offset       <= '0;
            mv_dst          <= '0;
            idx_reg         <= '0;
            src_reg         <= '0;
            off_reg         <= '0;
            dst_reg         <= '0;
            src_top_reg     <= '0;
            src_up_reg      <= '0;
            src_empty_reg   <= 1'b0;
            dst_top_reg     <= '0;
            dst_empty_reg   <= 1'b0;
            legal_reg       <= 1'b0;
            check_phase_reg <= 1'b0;
        end else begin
            ready <= 1'b0;
            case (state_reg)
                IDLE: begin
                    state_reg  <= PROMPT;
                    ready      <= 1'b1;
                    successful <= 1'b1;
                end
                PROMPT: state_reg <= WAIT_IN;
                WAIT_IN: if (input_ready) begin
                    // Talon and stock moves carry no offset; stock moves carry no destination.
                    src_reg       <= source;
                    off_reg       <= (source == 4'd0 || source == 4'd8) ? 4'd0 : source_offset;
                    dst_reg       <= (source == 4'd8) ? 4'd0 : destination;
                    idx_reg       <= '0;
                    src_top_reg   <= '0;
                    src_up_reg    <= '0;
                    src_empty_reg <= 1'b1;
                    dst_top_reg   <= '0;
                    dst_empty_reg <= 1'b1;
                    state_reg     <= SCAN_SRC;
                end
                SCAN_SRC: begin
                    if (scan_card != '0) begin
                        src_top_reg   <= idx_reg;
                        src_empty_reg <= 1'b0;
                    end
                    if (scan_card[0]) src_up_reg <= src_up_reg + 5'd1;
                    if (idx_reg == LAST_IDX) begin
                        idx_reg   <= '0;
                        state_reg <= SCAN_DST;
                    end else begin
                        idx_reg <= idx_reg + 5'd1;
                    end
                end
                SCAN_DST: begin
                    if (scan_card != '0) begin
                        dst_top_reg   <= scan_card;
                        dst_empty_reg <= 1'b0;
                    end
                    if (idx_reg == LAST_IDX) begin
                        idx_reg         <= '0;
                        check_phase_reg <= 1'b0;
                        state_reg       <= CHECK;
                    end else begin
                        idx_reg <= idx_reg + 5'd1;
                    end
                end
                CHECK: begin
                    // Two edges here keep the verdict at a fixed 40 cycles after capture.
                    if (!check_phase_reg) begin
                        legal_reg       <= legal;
                        check_phase_reg <= 1'b1;
                    end else begin
                        check_phase_reg <= 1'b0;
                        if (legal_reg) begin
                            state_reg <= EXEC;
                            mv_valid  <= 1'b1;
                            mv_src    <= src_reg;
                            mv_offset <= off_reg;
                            mv_dst    <= dst_reg;
                        end else begin
                            state_reg  <= REJECT;
                            ready      <= 1'b1;
                            successful <= 1'b0;
                        end
                    end
                end
                EXEC: if (mv_done) begin
                    mv_valid   <= 1'b0;
                    ready      <= 1'b1;
                    successful <= 1'b1;
                    state_reg  <= WAIT_IN;
                end
                REJECT:  state_reg <= WAIT_IN;
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef MOVE_COUNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            move_count <= '0;
        else if ((state_reg == EXEC) && mv_done && (move_count != {CNT_W{1'b1}}))
            move_count <= move_count + 1'b1;
    end
`else
    logic [CNT_W-1:0] unused_cnt;
    assign unused_cnt = '0;
`endif

endmodule

// File: tb/tb_move_checker.sv
// Scoreboard bench for move_checker: a list-based pile model predicts each verdict, a monitor
// pops expected responses whenever ready or a rising mv_valid appears.
module tb_move_checker;
    localparam int CARD_W    = 7;
    localparam int TAB_DEPTH = 19;

    logic clk = 1'b0;
    logic rst;
    logic ready, successful, input_ready, stock_empty, mv_valid, mv_done;
    logic [3:0] source, source_offset, destination, mv_src, mv_offset, mv_dst;
    logic [CARD_W-1:0] talon_top;
    logic [TAB_DEPTH*CARD_W-1:0] tableau1, tableau2, tableau3, tableau4, tableau5, tableau6, tableau7;
    logic [4*CARD_W-1:0] foundation_cards;
`ifdef MOVE_COUNT_EN
    logic [15:0] move_count;
`endif

    move_checker dut (
        .clk(clk), .rst(rst), .ready(ready), .successful(successful), .input_ready(input_ready),
        .source(source), .source_offset(source_offset), .destination(destination),
        .talon_top(talon_top), .stock_empty(stock_empty),
        .tableau1(tableau1), .tableau2(tableau2), .tableau3(tableau3), .tableau4(tableau4),
        .tableau5(tableau5), .tableau6(tableau6), .tableau7(tableau7),
        .foundation_cards(foundation_cards), .mv_valid(mv_valid), .mv_src(mv_src),
        .mv_offset(mv_offset), .mv_dst(mv_dst), .mv_done(mv_done)
`ifdef MOVE_COUNT_EN
        , .move_count(move_count)
`endif
    );

    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // kind 0: ready with successful=1, kind 1: ready with successful=0, kind 2: mv_valid rising
    typedef struct { int kind; int at; logic [3:0] s, o, d; } exp_t;
    exp_t sb[$];

    // Board model: piles listed bottom to top.
    logic [6:0] pile [1:7][0:18];
    int         plen [1:7];
    logic [6:0] talon;
    logic       stock_e;
    logic [6:0] found [0:3];

    function automatic logic [TAB_DEPTH*CARD_W-1:0] pack(input int p);
        logic [TAB_DEPTH*CARD_W-1:0] v;
        v = '0;
        for (int i = 0; i < plen[p]; i++) v[i*CARD_W +: CARD_W] = pile[p][i];
        return v;
    endfunction

    task automatic apply_board();
        tableau1 = pack(1); tableau2 = pack(2); tableau3 = pack(3); tableau4 = pack(4);
        tableau5 = pack(5); tableau6 = pack(6); tableau7 = pack(7);
        talon_top = talon;
        stock_empty = stock_e;
        foundation_cards = {found[3], found[2], found[1], found[0]};
    endtask

    task automatic clear_board();
        for (int p = 1; p <= 7; p++) plen[p] = 0;
        for (int s = 0; s < 4; s++) found[s] = '0;
        talon = '0;
        stock_e = 1'b0;
    endtask

    task automatic add(input int p, input logic [6:0] c);
        pile[p][plen[p]] = c;
        plen[p]++;
    endtask

    function automatic logic [6:0] rand_card(input bit up);
        return {4'($urandom_range(1, 13)), 2'($urandom_range(0, 3)), up};
    endfunction

    function automatic bit model_legal(input int s, input int o, input int d);
        logic [6:0] base, top, f;
        int up, n;
        if (s >= 9) return 0;
        if (s == 8) return !(stock_e && talon == 0);
        if (s == 0) o = 0;
        if (d > 7) return 0;
        if (s >= 1 && s == d) return 0;
        if (s == 0) begin
            if (talon == 0) return 0;
            base = talon;
        end else begin
            n = plen[s];
            if (n == 0) return 0;
            up = 0;
            for (int i = 0; i < n; i++) up += int'(pile[s][i][0]);
            if (o + 1 > up) return 0;
            base = pile[s][n-1-o];
        end
        if (d == 0) begin
            if (o != 0) return 0;
            f = found[base[2:1]];
            return int'(base[6:3]) == int'(f[6:3]) + 1;
        end
        if (plen[d] == 0) return int'(base[6:3]) == 13;
        top = pile[d][plen[d]-1];
        return top[0] && (int'(top[6:3]) == int'(base[6:3]) + 1) && (top[1] != base[1]);
    endfunction

    task automatic see_event(input int kind);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event got kind=%0d at cycle %0d, required no event", kind, cyc);
            return;
        end
        e = sb.pop_front();
        if (kind != e.kind || (e.kind != 0 && cyc != e.at) ||
            (e.kind == 2 && {mv_src, mv_offset, mv_dst} != {e.s, e.o, e.d})) begin
            errors++;
            $display("FAIL response got kind=%0d cyc=%0d src=%0d off=%0d dst=%0d, required kind=%0d cyc=%0d src=%0d off=%0d dst=%0d",
                     kind, cyc, mv_src, mv_offset, mv_dst, e.kind, e.at, e.s, e.o, e.d);
        end else begin
            $display("txn kind=%0d cyc=%0d src=%0d off=%0d dst=%0d ok", kind, cyc, mv_src, mv_offset, mv_dst);
        end
    endtask

    // Monitor
    initial begin
        logic prev_v;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_v = 1'b0;
            end else begin
                if (mv_valid && !prev_v) see_event(2);
                if (ready) see_event(successful ? 0 : 1);
                prev_v = mv_valid;
            end
        end
    end

    task automatic wait_for(input bit want_ready, input string tag);
        int n;
        n = 0;
        while (!(want_ready ? ready : mv_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL timeout_%s got no pulse in 200 cycles, required one", tag);
        end
    endtask

    task automatic push_exp(input int kind, input int at, input logic [3:0] s, o, d);
        exp_t e;
        e.kind = kind; e.at = at; e.s = s; e.o = o; e.d = d;
        sb.push_back(e);
    endtask

    // Called just after a ready pulse has been seen.
    task automatic issue_move(input logic [3:0] s, input logic [3:0] o, input logic [3:0] d, input bit spurious);
        bit lg;
        int cap;
        apply_board();
        lg = model_legal(int'(s), int'(o), int'(d));
        @(negedge clk);
        source = s; source_offset = o; destination = d; input_ready = 1'b1;
        @(posedge clk);
        #1;
        cap = cyc;
        input_ready = 1'b0;
        source = 4'($urandom); source_offset = 4'($urandom); destination = 4'($urandom);
        if (lg) begin
            push_exp(2, cap + 40, s, (s == 0 || s == 8) ? 4'd0 : o, (s == 8) ? 4'd0 : d);
            push_exp(0, 0, 4'd0, 4'd0, 4'd0);
        end else begin
            push_exp(1, cap + 40, 4'd0, 4'd0, 4'd0);
        end
        if (spurious) begin
            mv_done = 1'b1;
            repeat (3) @(negedge clk);
            mv_done = 1'b0;
        end
        if (lg) begin
            wait_for(1'b0, "mv_valid");
            repeat ($urandom_range(0, 3)) @(negedge clk);
            mv_done = 1'b1;
            @(negedge clk);
            mv_done = 1'b0;
        end
        wait_for(1'b1, "ready");
    endtask

    task automatic random_board();
        int n, k;
        clear_board();
        for (int p = 1; p <= 7; p++) begin
            n = $urandom_range(0, 6);
            k = (n > 0) ? $urandom_range(0, n - 1) : 0;
            for (int i = 0; i < n; i++) add(p, rand_card(i >= k));
        end
        talon = ($urandom_range(0, 3) == 0) ? 7'd0 : rand_card(1'b1);
        stock_e = 1'($urandom_range(0, 1));
        for (int s = 0; s < 4; s++)
            found[s] = ($urandom_range(0, 2) == 0) ? 7'd0 : {4'($urandom_range(1, 12)), 2'(s), 1'b1};
    endtask

    // Biases the board so that the chosen move has a fitting destination.
    task automatic make_fit(input int s, input int o, input int d);
        logic [6:0] base;
        if (s == 0) base = talon;
        else if (s >= 1 && s <= 7 && plen[s] > o) base = pile[s][plen[s]-1-o];
        else return;
        if (base == 0) return;
        if (d == 0) begin
            found[base[2:1]] = (base[6:3] == 4'd1) ? 7'd0 : {base[6:3] - 4'd1, base[2:1], 1'b1};
        end else if (d <= 7 && d != s) begin
            if (base[6:3] == 4'd13) plen[d] = 0;
            else add(d, {base[6:3] + 4'd1, base[2:1] ^ 2'b01, 1'b1});
        end
    endtask

    initial begin
        int s, o, d;
        rst = 1'b0; input_ready = 1'b0; mv_done = 1'b0;
        source = '0; source_offset = '0; destination = '0;
        clear_board();
        apply_board();
        #1;
        checks++;
        if ({ready, successful, mv_valid, mv_src, mv_offset, mv_dst} != '0) begin
            errors++;
            $display("FAIL reset_outputs got %b, required all zero", {ready, successful, mv_valid, mv_src, mv_offset, mv_dst});
        end
        repeat (3) @(negedge clk);
        push_exp(0, 0, 4'd0, 4'd0, 4'd0);
        rst = 1'b1;
        wait_for(1'b1, "ready");

        // Directed cases
        clear_board(); talon = 7'b0111001; add(2, 7'b1000111); issue_move(4'd0, 4'd3, 4'd2, 1'b0);
        clear_board(); add(4, 7'b1101101); issue_move(4'd4, 4'd0, 4'd3, 1'b0);
        clear_board(); add(4, 7'b1100101); issue_move(4'd4, 4'd0, 4'd3, 1'b0);
        clear_board(); add(1, 7'b0001111); issue_move(4'd1, 4'd0, 4'd0, 1'b1);
        clear_board(); add(1, 7'b0010001); add(1, 7'b0001111); issue_move(4'd1, 4'd1, 4'd0, 1'b0);
        clear_board(); add(5, 7'b1010100); add(5, 7'b1001011); add(5, 7'b1000001);
        issue_move(4'd5, 4'd2, 4'd1, 1'b0);
        clear_board(); add(6, 7'b0101011); add(6, 7'b0100001); issue_move(4'd6, 4'd0, 4'd6, 1'b0);
        issue_move(4'd9, 4'd0, 4'd1, 1'b0);
        stock_e = 1'b1; talon = 7'd0; issue_move(4'd8, 4'd2, 4'd3, 1'b0);
        stock_e = 1'b0; issue_move(4'd8, 4'd5, 4'd3, 1'b0);
        clear_board(); add(3, 7'b1101001); add(7, 7'b1100001); issue_move(4'd7, 4'd0, 4'd3, 1'b0);

        // Randomized moves
        for (int t = 0; t < 40; t++) begin
            random_board();
            s = ($urandom_range(0, 9) == 0) ? $urandom_range(9, 15) : $urandom_range(0, 8);
            o = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 2);
            d = ($urandom_range(0, 9) == 0) ? $urandom_range(8, 15) : $urandom_range(0, 7);
            if ($urandom_range(0, 1) == 1) make_fit(s, o, d);
            issue_move(4'(s), 4'(o), 4'(d), $urandom_range(0, 3) == 0);
        end

        // Reset in the middle of the destination scan
        clear_board(); add(4, 7'b1101101);
        apply_board();
        @(negedge clk);
        source = 4'd4; source_offset = 4'd0; destination = 4'd3; input_ready = 1'b1;
        @(posedge clk);
        #1;
        input_ready = 1'b0;
        repeat (25) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({ready, successful, mv_valid, mv_src, mv_offset, mv_dst} != '0) begin
            errors++;
            $display("FAIL midscan_reset got %b, required all zero", {ready, successful, mv_valid, mv_src, mv_offset, mv_dst});
        end
        sb.delete();
        repeat (2) @(negedge clk);
        push_exp(0, 0, 4'd0, 4'd0, 4'd0);
        rst = 1'b1;
        wait_for(1'b1, "ready");
        issue_move(4'd4, 4'd0, 4'd3, 1'b0);

        repeat (5) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL pending_responses got %0d outstanding, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
